// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder8b_fa.sv
// One-bit combinational full adder used by the serial datapath.
module full_adder1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder8b.sv
// Bit-serial adder: processes one bit pair per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a Sub input selecting A-B (borrow on Cout).
module serial_adder8b
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sum_bit, carry_nxt;
    logic             accept, last;
    logic             cout_final;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    assign cout_final = carry_nxt ^ sub_q;
`else
    assign cout_final = carry_nxt;
`endif

    assign accept = (state != RUN) && Start;
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign r_nxt  = {sum_bit, r_sh};

    full_adder1b u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = Start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

    // Subtract is A + ~B + 1: B is inverted on load and the carry preset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= A;
            cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            b_sh  <= Sub ? ~B : B;
            carry <= Sub;
            sub_q <= Sub;
`else
            b_sh  <= B;
            carry <= 1'b0;
`endif
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= r_nxt[WIDTH-1:1];
            carry <= carry_nxt;
            cnt   <= cnt + 1'b1;
            if (last) begin
                S    <= r_nxt;
                Cout <= cout_final;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder8b.sv
// Scoreboard bench for serial_adder8b: driver queues expected {Cout,S}, monitor checks on Done.
module tb_serial_adder8b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Sub = 1'b0;
    logic [7:0] S;
    logic       Cout, Busy, Done;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder8b #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (Sub),
`endif
        .S     (S),
        .Cout  (Cout),
        .Busy  (Busy),
        .Done  (Done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: true arithmetic on the operands, borrow = (a < b) in subtract mode.
    function automatic logic [8:0] model(input int a, input int b, input bit sub);
        int r;
        if (sub) return {a < b, 8'((a - b) & 255)};
        r = a + b;
        return 9'(r);
    endfunction

    always @(negedge clk) begin
        if (rst_n && Done) begin
            logic [8:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sum", int'(S), int'(e[7:0]));
                check("cout", int'(Cout), int'(e[8]));
            end
        end
    end

    task automatic wait_done();
        int i = 0;
        while (!Done && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!Done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int a, input int b, input bit sub);
        int busy_n = 0;
        int i = 0;
        @(negedge clk);
        A = 8'(a); B = 8'(b); Sub = sub; Start = 1'b1;
        exp_q.push_back(model(a, b, sub));
        @(negedge clk);
        Start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Sub = ~sub;
        while (!Done && i < 40) begin
            if (Busy) busy_n++;
            @(negedge clk);
            i++;
        end
        check("done_seen", int'(Done), 1);
        check("busy_cycles", busy_n, 8);
        @(negedge clk);
        check("done_one_cycle", int'(Done), 0);
    endtask

    initial begin
        int d0, t1, t2;
        #2;
        check("rst_S", int'(S), 0);
        check("rst_Cout", int'(Cout), 0);
        check("rst_Busy", int'(Busy), 0);
        check("rst_Done", int'(Done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(10, 3, 0);
        run_op(255, 1, 0);
        run_op(0, 0, 0);
        run_op(255, 255, 0);

        // Start and operand changes in the 3rd RUN cycle must be ignored.
        d0 = done_cnt;
        @(negedge clk);
        A = 8'd20; B = 8'd30; Start = 1'b1;
        exp_q.push_back(model(20, 30, 0));
        @(negedge clk); Start = 1'b0;
        @(negedge clk);
        @(negedge clk); Start = 1'b1; A = 8'd99; B = 8'd77;
        @(negedge clk); Start = 1'b0;
        repeat (14) @(negedge clk);
        check("ignored_start_dones", done_cnt - d0, 1);
        check("idle_after_ignore", int'(Busy), 0);

        // Reset during the 4th RUN cycle aborts without Done.
        @(negedge clk);
        A = 8'd50; B = 8'd60; Start = 1'b1;
        exp_q.push_back(model(50, 60, 0));
        @(negedge clk); Start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_S", int'(S), 0);
        check("abort_Cout", int'(Cout), 0);
        check("abort_Busy", int'(Busy), 0);
        check("abort_Done", int'(Done), 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_op(7, 8, 0);

        // Start held across Done gives back-to-back operations.
        @(negedge clk);
        A = 8'd100; B = 8'd27; Start = 1'b1;
        exp_q.push_back(model(100, 27, 0));
        @(negedge clk);
        wait_done();
        t1 = cyc;
        A = 8'd200; B = 8'd100;
        exp_q.push_back(model(200, 100, 0));
        @(negedge clk);
        Start = 1'b0;
        wait_done();
        t2 = cyc;
        check("b2b_gap", t2 - t1, 9);
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(5, 10, 1);
        run_op(100, 100, 1);
`endif

        for (int k = 0; k < 20; k++) begin
`ifdef SERIAL_ADDER_SUB_EN
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
`else
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
`endif
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_adder8b.md
SERIAL_ADDER8B -- requirements
Module: serial_adder8b

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Start, input, 1 bit: request to begin an operation, sampled on the rising edge.
REQ-005 The block SHALL have port A, input, WIDTH bits: first operand, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: second operand, unsigned.
REQ-007 The block SHALL have port S, output, WIDTH bits: registered result.
REQ-008 The block SHALL have port Cout, output, 1 bit: registered carry-out, or Borrow in subtract mode (REQ-023).
REQ-009 The block SHALL have port Busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking the cycle in which S and Cout are valid.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, the edge sampling Start=1 (the acceptance edge E0) SHALL latch A and B into internal shift registers, clear the carry flop and bit counter, and enter RUN.
REQ-013 Each RUN edge SHALL add one bit pair, LSB first, through a 1-bit full adder using the carry flop, shift the sum bit into the result register and update the carry flop.
REQ-014 Edge E0+WIDTH SHALL process the MSB, load S and Cout and enter DONE, so that Done=1 in the cycle following E0+WIDTH.
REQ-015 Done SHALL be high for exactly one cycle; DONE SHALL go to IDLE on the next edge, or directly to RUN if Start=1 on that edge, giving back-to-back operation with no gap.
REQ-016 Busy SHALL be 1 exactly while the state is RUN.
REQ-017 Start asserted while in RUN SHALL be ignored, and changes to A or B during RUN SHALL not affect the result.
REQ-018 S and Cout SHALL hold their last result until the next completion, and SHALL change only on the edge that enters DONE.
REQ-019 The result SHALL be the WIDTH-bit sum modulo 2^WIDTH, with Cout equal to bit WIDTH of the true sum A+B.

Reset
REQ-020 rst_n=0 SHALL immediately, without waiting for a clock edge, force state to IDLE and set S=0, Cout=0, Busy=0, Done=0, and clear the carry flop and counter.
REQ-021 Reset asserted during RUN SHALL abort the operation with no Done pulse, and after release the block SHALL accept a new Start normally.

Configuration
REQ-022 Macro SERIAL_ADDER_SUB_EN SHALL, when defined, add input port Sub (1 bit), latched at the acceptance edge E0.
REQ-023 With SERIAL_ADDER_SUB_EN defined and Sub=1, the block SHALL compute A-B by inverting B bits and presetting the carry flop to 1, with Cout = NOT final carry (1 when A<B).
REQ-024 Without SERIAL_ADDER_SUB_EN, the Sub port and all subtract logic SHALL be absent and the block SHALL only add.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-026 The 1-bit combinational sum/carry logic SHALL be a sub-module named full_adder1b, instantiated once.

Verification
REQ-027 Reset release, then A=10, B=3, Start pulse -> Busy high for 8 cycles, then Done for one cycle with S=13, Cout=0.
REQ-028 A=255, B=1 -> S=0, Cout=1; A=0, B=0 -> S=0, Cout=0.
REQ-029 Start pulse plus A/B changes in the 3rd RUN cycle -> ignored; the first result is unaffected and there is exactly one Done.
REQ-030 rst_n low in the 4th RUN cycle -> outputs go to 0 at once with no Done; a following operation 7+8 -> S=15.
REQ-031 Start held high across Done -> back-to-back results with Done pulses 9 cycles apart.
REQ-032 With SERIAL_ADDER_SUB_EN and Sub=1: 5-10 -> S=251, Cout=1; 100-100 -> S=0, Cout=0.
